tnoc_vc_credit_scheduler: RTL and testbench

Per-output-port scheduler that shares one physical link among `CHANNELS` virtual-channel input buffers. It grants the link a whole packet at a time using round-robin among VCs. Each VC has a credit counter mirroring free slots in the downstream per-VC FIFO. It sits between the per-VC FIFOs and the flit mux, and drives the FIFO pops and the mux select.

---
 rtl/tnoc_vc_credit_scheduler.sv | 153 +++++++++++++++
 tb/tb_tnoc_vc_credit_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnoc_vc_credit_scheduler.sv
// Per-output-port virtual-channel scheduler: whole-packet round-robin
// arbitration over CHANNELS VC FIFOs, gated by per-VC downstream credits.
module tnoc_vc_credit_scheduler #(
   parameter int CHANNELS = 2,
   parameter int CREDITS  = 8,
   parameter int CW       = $clog2(CREDITS + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CHANNELS-1:0]    i_valid,
   input  logic [CHANNELS-1:0]    i_head,
   input  logic [CHANNELS-1:0]    i_tail,
   input  logic [CHANNELS-1:0]    i_credit_return,
   output logic [CHANNELS-1:0]    o_grant,
   output logic [CHANNELS-1:0]    o_send,
   output logic [CHANNELS*CW-1:0] o_credit,
   output logic                   o_locked,
   output logic                   o_credit_error
);

   localparam int            PW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CW-1:0] CR_MAX  = CW'(CREDITS);
   localparam logic [CW-1:0] CR_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_RST = PW'(CHANNELS - 1);

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

   state_t              state_reg, state_next;
   logic [PW-1:0]       lock_vc_reg, lock_vc_next;
   logic [PW-1:0]       ptr_reg, ptr_next;
   logic [CW-1:0]       cr_reg [CHANNELS];
   logic                error_reg;

   logic [CHANNELS-1:0] has_credit;
   logic [CHANNELS-1:0] elig;
   logic [CHANNELS-1:0] overflow;
   logic [CHANNELS-1:0] grant;
   logic [CHANNELS-1:0] send;
   logic                win_found;
   logic [PW-1:0]       win_idx;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_vc
         assign has_credit[gi] = (cr_reg[gi] != '0);
         assign elig[gi]       = i_valid[gi] & i_head[gi] & has_credit[gi];
         // A return with no matching send while already full has nowhere to go.
         assign overflow[gi]   = i_credit_return[gi] & ~send[gi] & (cr_reg[gi] == CR_MAX);
         assign o_credit[gi*CW +: CW] = cr_reg[gi];
      end
   endgenerate

   // Round-robin search starting just after the last granted VC.
   always_comb begin
      int            idx;
      logic [PW-1:0] idx_sel;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      idx_sel   = '0;
      for (int k = 1; k <= CHANNELS; k++) begin
         idx     = (int'(ptr_reg) + k) % CHANNELS;
         idx_sel = idx[PW-1:0];
         if (!win_found && elig[idx_sel]) begin
            win_found = 1'b1;
            win_idx   = idx_sel;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      lock_vc_next = lock_vc_reg;
      ptr_next     = ptr_reg;
      grant        = '0;
      send         = '0;
      case (state_reg)
         ST_IDLE: begin
            if (win_found) begin
               grant[win_idx] = 1'b1;
               send[win_idx]  = 1'b1;
               ptr_next       = win_idx;
               if (!i_tail[win_idx]) begin
                  state_next   = ST_LOCKED;
                  lock_vc_next = win_idx;
               end
            end
         end
         ST_LOCKED: begin
            grant[lock_vc_reg] = 1'b1;
            if (i_valid[lock_vc_reg] && has_credit[lock_vc_reg]) begin
               send[lock_vc_reg] = 1'b1;
               if (i_tail[lock_vc_reg]) begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      // Nothing may leave while reset is held, even though IDLE arbitration is combinational.
      if (!rst_n) begin
         grant = '0;
         send  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         lock_vc_reg <= '0;
         ptr_reg     <= PTR_RST;
      end else begin
         state_reg   <= state_next;
         lock_vc_reg <= lock_vc_next;
         ptr_reg     <= ptr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cr_reg[i] <= CR_MAX;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (send[i] && !i_credit_return[i]) begin
               cr_reg[i] <= cr_reg[i] - CR_ONE;
            end else if (!send[i] && i_credit_return[i] && (cr_reg[i] != CR_MAX)) begin
               cr_reg[i] <= cr_reg[i] + CR_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_reg <= 1'b0;
      end else if (|overflow) begin
         error_reg <= 1'b1;
      end
   end

   assign o_grant        = grant;
   assign o_send         = send;
   assign o_locked       = (state_reg == ST_LOCKED);
   assign o_credit_error = error_reg;

endmodule

// File: tb/tb_tnoc_vc_credit_scheduler.sv
// Directed scenarios followed by random traffic, all checked against a
// packet/credit-level reference model evaluated every cycle.
module tb_tnoc_vc_credit_scheduler;

   localparam int CH = 2;
   localparam int CREDITS = 4;
   localparam int CW = $clog2(CREDITS + 1);

   logic           clk = 1'b0;
   logic           rst_n;
   logic [CH-1:0]  valid, head, tail, ret;
   logic [CH-1:0]  o_grant, o_send;
   logic [CH*CW-1:0] o_credit;
   logic           o_locked, o_credit_error;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // reference model state
   int            m_cr [CH];
   int            m_ptr;
   bit            m_lock;
   int            m_lv;
   bit            m_err;
   int            m_win;
   logic [CH-1:0] exp_grant, exp_send;
   logic [CH*CW-1:0] exp_credit;

   tnoc_vc_credit_scheduler #(
      .CHANNELS(CH),
      .CREDITS (CREDITS)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_valid        (valid),
      .i_head         (head),
      .i_tail         (tail),
      .i_credit_return(ret),
      .o_grant        (o_grant),
      .o_send         (o_send),
      .o_credit       (o_credit),
      .o_locked       (o_locked),
      .o_credit_error (o_credit_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) m_cr[i] = CREDITS;
      m_ptr  = CH - 1;
      m_lock = 1'b0;
      m_lv   = 0;
      m_err  = 1'b0;
   endtask

   task automatic model_eval();
      int c;
      exp_grant = '0;
      exp_send  = '0;
      m_win     = -1;
      if (!m_lock) begin
         for (int k = 1; k <= CH; k++) begin
            c = (m_ptr + k) % CH;
            if (m_win < 0 && valid[c] && head[c] && m_cr[c] > 0) m_win = c;
         end
         if (m_win >= 0) begin
            exp_grant[m_win] = 1'b1;
            exp_send[m_win]  = 1'b1;
         end
      end else begin
         exp_grant[m_lv] = 1'b1;
         if (valid[m_lv] && m_cr[m_lv] > 0) exp_send[m_lv] = 1'b1;
      end
      for (int i = 0; i < CH; i++) exp_credit[i*CW +: CW] = CW'(m_cr[i]);
   endtask

   task automatic model_update();
      for (int i = 0; i < CH; i++) begin
         m_cr[i] = m_cr[i] - int'(exp_send[i]) + int'(ret[i]);
         if (m_cr[i] > CREDITS) begin
            m_cr[i] = CREDITS;
            m_err   = 1'b1;
         end
      end
      if (!m_lock && m_win >= 0) begin
         m_ptr = m_win;
         if (!tail[m_win]) begin
            m_lock = 1'b1;
            m_lv   = m_win;
         end
      end else if (m_lock && exp_send[m_lv] && tail[m_lv]) begin
         m_lock = 1'b0;
      end
   endtask

   // Inputs are already set; check outputs mid-cycle against the model.
   task automatic sample();
      @(negedge clk);
      model_eval();
      $display("cyc %0d v=%b h=%b t=%b r=%b | grant=%b send=%b lock=%b cr=%h err=%b",
               cyc, valid, head, tail, ret, o_grant, o_send, o_locked, o_credit, o_credit_error);
      chk("grant", 32'(o_grant), 32'(exp_grant));
      chk("send", 32'(o_send), 32'(exp_send));
      chk("locked", 32'(o_locked), 32'(m_lock));
      chk("credit", 32'(o_credit), 32'(exp_credit));
      chk("credit_error", 32'(o_credit_error), 32'(m_err));
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic drive(input logic [CH-1:0] v, input logic [CH-1:0] h,
                        input logic [CH-1:0] t, input logic [CH-1:0] r);
      valid = v;
      head  = h;
      tail  = t;
      ret   = r;
   endtask

   task automatic restore();
      for (int k = 0; k < CREDITS; k++) begin
         logic [CH-1:0] r;
         r = '0;
         for (int i = 0; i < CH; i++) r[i] = (m_cr[i] < CREDITS);
         drive('0, '0, '0, r);
         sample();
         advance();
      end
      drive('0, '0, '0, '0);
   endtask

   initial begin
      logic [CH-1:0] prev;
      rst_n = 1'b0;
      drive(2'b11, 2'b11, 2'b11, 2'b00);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_grant", 32'(o_grant), 32'd0);
      chk("rst_send", 32'(o_send), 32'd0);
      chk("rst_locked", 32'(o_locked), 32'd0);
      chk("rst_credit", 32'(o_credit), 32'b100_100);
      chk("rst_error", 32'(o_credit_error), 32'd0);
      rst_n = 1'b1;

      // Alternating single-flit packets; each send's credit comes back next cycle.
      prev = '0;
      for (int n = 0; n < 6; n++) begin
         drive(2'b11, 2'b11, 2'b11, prev);
         sample();
         chk("alt_send", 32'(o_send), (n % 2 == 0) ? 32'd1 : 32'd2);
         chk("alt_locked", 32'(o_locked), 32'd0);
         prev = exp_send;
         advance();
      end
      restore();

      // 4-flit packet on VC0 while VC1 waits with a head from cycle 1.
      drive(2'b01, 2'b01, 2'b00, 2'b00);
      sample(); chk("lock_c0_grant", 32'(o_grant), 32'd1); advance();
      for (int n = 1; n < 4; n++) begin
         drive(2'b11, 2'b10, (n == 3) ? 2'b01 : 2'b00, 2'b00);
         sample();
         chk("lock_grant", 32'(o_grant), 32'd1);
         chk("lock_send", 32'(o_send), 32'd1);
         advance();
      end
      drive(2'b10, 2'b10, 2'b10, 2'b00);
      sample(); chk("lock_c4_send", 32'(o_send), 32'd2); advance();
      restore();

      // Credit exhaustion inside a 5-flit packet.
      drive(2'b01, 2'b01, 2'b00, 2'b00);
      sample(); chk("exh_head", 32'(o_send), 32'd1); advance();
      for (int n = 1; n < 4; n++) begin
         drive(2'b01, 2'b00, 2'b00, 2'b00);
         sample(); chk("exh_body", 32'(o_send), 32'd1); advance();
      end
      for (int n = 0; n < 2; n++) begin
         drive(2'b11, 2'b10, 2'b10, 2'b00);
         sample();
         chk("exh_stall_send", 32'(o_send), 32'd0);
         chk("exh_stall_grant", 32'(o_grant), 32'd1);
         chk("exh_stall_locked", 32'(o_locked), 32'd1);
         chk("exh_stall_cr0", 32'(o_credit[CW-1:0]), 32'd0);
         advance();
      end
      drive(2'b11, 2'b10, 2'b10, 2'b01);
      sample(); chk("exh_ret_cycle_send", 32'(o_send), 32'd0); advance();
      drive(2'b11, 2'b10, 2'b11, 2'b00);
      sample(); chk("exh_after_ret_send", 32'(o_send), 32'd1); advance();
      drive(2'b11, 2'b10, 2'b10, 2'b00);
      sample(); chk("exh_vc1_next", 32'(o_send), 32'd2); advance();
      restore();

      // Simultaneous send and return on VC0 at cr=3.
      drive(2'b01, 2'b01, 2'b01, 2'b00);
      sample(); advance();
      drive(2'b01, 2'b01, 2'b01, 2'b01);
      sample(); chk("simul_cr_before", 32'(o_credit[CW-1:0]), 32'd3); advance();
      drive('0, '0, '0, '0);
      sample(); chk("simul_cr_after", 32'(o_credit[CW-1:0]), 32'd3); advance();
      restore();

      // Overflow return on VC1 while full.
      drive('0, '0, '0, 2'b10);
      sample(); chk("ovf_before", 32'(o_credit_error), 32'd0); advance();
      drive('0, '0, '0, '0);
      for (int n = 0; n < 2; n++) begin
         sample();
         chk("ovf_error", 32'(o_credit_error), 32'd1);
         chk("ovf_cr1", 32'(o_credit[CW +: CW]), 32'(CREDITS));
         advance();
      end

      // Reset in the middle of a VC1 packet.
      drive(2'b10, 2'b10, 2'b00, 2'b00);
      sample(); chk("rstmid_head", 32'(o_send), 32'd2); advance();
      drive(2'b10, 2'b00, 2'b00, 2'b00);
      sample(); chk("rstmid_body", 32'(o_send), 32'd2); advance();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rstmid_locked", 32'(o_locked), 32'd0);
      chk("rstmid_grant", 32'(o_grant), 32'd0);
      chk("rstmid_send", 32'(o_send), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(2'b11, 2'b11, 2'b11, 2'b00);
      sample();
      chk("rstmid_first_grant", 32'(o_grant), 32'd1);
      chk("rstmid_credit", 32'(o_credit), 32'b100_100);
      advance();

      // Random traffic against the model.
      for (int n = 0; n < 300; n++) begin
         logic [CH-1:0] r;
         for (int i = 0; i < CH; i++) r[i] = ($urandom_range(0, 3) == 0);
         drive(CH'($urandom), CH'($urandom), CH'($urandom), r);
         sample();
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
